// File: rtl/rv_ctrl_pkg.sv
// Shared encodings for the multi-cycle RV32I control path: opcodes, mux selects,
// ALU operations and FSM states.
package rv_ctrl_pkg;

  localparam int unsigned OP_W    = 7;
  localparam int unsigned STATE_W = 4;

  localparam logic [OP_W-1:0] OP_LOAD   = 7'b0000011;
  localparam logic [OP_W-1:0] OP_STORE  = 7'b0100011;
  localparam logic [OP_W-1:0] OP_RTYPE  = 7'b0110011;
  localparam logic [OP_W-1:0] OP_ITYPE  = 7'b0010011;
  localparam logic [OP_W-1:0] OP_LUI    = 7'b0110111;
  localparam logic [OP_W-1:0] OP_BRANCH = 7'b1100011;
  localparam logic [OP_W-1:0] OP_JAL    = 7'b1101111;
  localparam logic [OP_W-1:0] OP_JALR   = 7'b1100111;

  typedef enum logic [3:0] {
    ALU_ADD   = 4'b0000,
    ALU_SUB   = 4'b0001,
    ALU_AND   = 4'b0010,
    ALU_OR    = 4'b0011,
    ALU_XOR   = 4'b0100,
    ALU_SLT   = 4'b0101,
    ALU_SLL   = 4'b0110,
    ALU_SRL   = 4'b0111,
    ALU_SRA   = 4'b1000,
    ALU_SLTU  = 4'b1001,
    ALU_PASSB = 4'b1010
  } alu_ctrl_e;

  typedef enum logic [2:0] {
    IMM_I = 3'b000,
    IMM_S = 3'b001,
    IMM_B = 3'b010,
    IMM_J = 3'b011,
    IMM_U = 3'b100
  } imm_src_e;

  typedef enum logic [1:0] {
    RES_ALUOUT    = 2'b00,
    RES_READDATA  = 2'b01,
    RES_ALURESULT = 2'b10
  } result_src_e;

  typedef enum logic [1:0] {
    SRCA_PC    = 2'b00,
    SRCA_OLDPC = 2'b01,
    SRCA_RS1   = 2'b10
  } alu_src_a_e;

  typedef enum logic [1:0] {
    SRCB_RS2  = 2'b00,
    SRCB_IMM  = 2'b01,
    SRCB_FOUR = 2'b10
  } alu_src_b_e;

  // Operation class handed to the ALU decoder by the sequencer.
  typedef enum logic [2:0] {
    CLS_ADD   = 3'd0,
    CLS_SUB   = 3'd1,
    CLS_PASSB = 3'd2,
    CLS_RTYPE = 3'd3,
    CLS_ITYPE = 3'd4
  } alu_class_e;

  typedef enum logic [STATE_W-1:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_MEMADR    = 4'd2,
    S_MEMREAD   = 4'd3,
    S_MEMWB     = 4'd4,
    S_MEMWRITE  = 4'd5,
    S_EXECUTER  = 4'd6,
    S_EXECUTEI  = 4'd7,
    S_ALUWB     = 4'd8,
    S_LUI       = 4'd9,
    S_BRANCH    = 4'd10,
    S_JAL       = 4'd11,
    S_JALR      = 4'd12,
    S_JALR_LINK = 4'd13,
    S_TRAP      = 4'd14
  } state_e;

  function automatic imm_src_e imm_src_for(input logic [OP_W-1:0] op);
    case (op)
      OP_STORE:  return IMM_S;
      OP_BRANCH: return IMM_B;
      OP_JAL:    return IMM_J;
      OP_LUI:    return IMM_U;
      default:   return IMM_I;
    endcase
  endfunction

endpackage

// File: rtl/alu_decoder.sv
// Maps the sequencer's operation class plus funct3/funct7[5] to an ALU operation.
module alu_decoder
  import rv_ctrl_pkg::*;
(
  input  alu_class_e  alu_class,
  input  logic [2:0]  funct3,
  input  logic        funct7b5,
  output alu_ctrl_e   alu_control_c
);

  always_comb begin
    alu_control_c = ALU_ADD;
    case (alu_class)
      CLS_SUB:   alu_control_c = ALU_SUB;
      CLS_PASSB: alu_control_c = ALU_PASSB;
      CLS_RTYPE, CLS_ITYPE: begin
        case (funct3)
          // funct7[5] only turns ADD into SUB for register-register ops
          3'b000:  alu_control_c = (alu_class == CLS_RTYPE && funct7b5) ? ALU_SUB : ALU_ADD;
          3'b001:  alu_control_c = ALU_SLL;
          3'b010:  alu_control_c = ALU_SLT;
          3'b011:  alu_control_c = ALU_SLTU;
          3'b100:  alu_control_c = ALU_XOR;
          3'b101:  alu_control_c = funct7b5 ? ALU_SRA : ALU_SRL;
          3'b110:  alu_control_c = ALU_OR;
          default: alu_control_c = ALU_AND;
        endcase
      end
      default:   alu_control_c = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_control_unit.sv
// Multi-cycle RV32I sequencer: drives the shared-ALU datapath through fetch,
// decode, execute, memory and writeback with a variable-latency memory handshake.
module multicycle_control_unit
  import rv_ctrl_pkg::*;
#(
  parameter int unsigned ALU_CTRL_W = 4,
  parameter int unsigned IMM_SRC_W  = 3,
  parameter int unsigned RETIRE_W   = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [6:0]            Op,
  input  logic [2:0]            Funct3,
  input  logic [6:0]            Funct7,
  input  logic                  Zero,
  input  logic                  Lt,
  input  logic                  Ltu,
  input  logic                  MemReady,
  output logic                  PCWrite,
  output logic                  AdrSrc,
  output logic                  MemWrite,
  output logic                  IRWrite,
  output logic [1:0]            ResultSrc,
  output logic [1:0]            ALUSrcA,
  output logic [1:0]            ALUSrcB,
  output logic [ALU_CTRL_W-1:0] ALUControl,
  output logic [IMM_SRC_W-1:0]  ImmSrc,
  output logic                  RegWrite,
  output logic                  IllegalInstr,
  output logic [RETIRE_W-1:0]   InstRetired,
  output logic [3:0]            State
);

  state_e        state, state_next, decode_next_c;
  alu_class_e    alu_class;
  alu_ctrl_e     alu_ctrl_c;
  imm_src_e      imm_src;
  result_src_e   result_src;
  alu_src_a_e    src_a;
  alu_src_b_e    src_b;
  logic          pc_write, ir_write, mem_write, reg_write, adr_src;
  logic          taken_c, retire_c;
  logic          illegal_q;
  logic [RETIRE_W-1:0] retired_q;
  logic          unused_funct7;

  assign unused_funct7 = ^{Funct7[6], Funct7[4:0]};

  alu_decoder u_alu_decoder (
    .alu_class     (alu_class),
    .funct3        (Funct3),
    .funct7b5      (Funct7[5]),
    .alu_control_c (alu_ctrl_c)
  );

  // Successor of DECODE; unsupported encodings land in TRAP.
  always_comb begin
    decode_next_c = S_TRAP;
    case (Op)
      OP_LOAD, OP_STORE: if (Funct3 == 3'b010) decode_next_c = S_MEMADR;
      OP_RTYPE:          decode_next_c = S_EXECUTER;
      OP_ITYPE:          decode_next_c = S_EXECUTEI;
      OP_LUI:            decode_next_c = S_LUI;
      OP_BRANCH:         if (Funct3[2:1] != 2'b01) decode_next_c = S_BRANCH;
      OP_JAL:            decode_next_c = S_JAL;
      OP_JALR:           decode_next_c = S_JALR;
      default:           decode_next_c = S_TRAP;
    endcase
  end

  always_comb begin
    taken_c = 1'b0;
    case (Funct3)
      3'b000:  taken_c = Zero;
      3'b001:  taken_c = !Zero;
      3'b100:  taken_c = Lt;
      3'b101:  taken_c = !Lt;
      3'b110:  taken_c = Ltu;
      3'b111:  taken_c = !Ltu;
      default: taken_c = 1'b0;
    endcase
  end

  // Next state and per-state datapath controls.
  always_comb begin
    state_next = state;
    pc_write   = 1'b0;
    ir_write   = 1'b0;
    mem_write  = 1'b0;
    reg_write  = 1'b0;
    adr_src    = 1'b0;
    result_src = RES_ALUOUT;
    src_a      = SRCA_PC;
    src_b      = SRCB_RS2;
    alu_class  = CLS_ADD;
    imm_src    = IMM_I;
    case (state)
      S_FETCH: begin
        src_b      = SRCB_FOUR;
        result_src = RES_ALURESULT;
        ir_write   = MemReady;
        pc_write   = MemReady;
        if (MemReady) state_next = S_DECODE;
      end
      S_DECODE: begin
        src_a      = SRCA_OLDPC;
        src_b      = SRCB_IMM;
        imm_src    = imm_src_for(Op);
        state_next = decode_next_c;
      end
      S_MEMADR: begin
        src_a      = SRCA_RS1;
        src_b      = SRCB_IMM;
        state_next = (Op == OP_STORE) ? S_MEMWRITE : S_MEMREAD;
      end
      S_MEMREAD: begin
        adr_src = 1'b1;
        if (MemReady) state_next = S_MEMWB;
      end
      S_MEMWB: begin
        result_src = RES_READDATA;
        reg_write  = 1'b1;
        state_next = S_FETCH;
      end
      S_MEMWRITE: begin
        adr_src   = 1'b1;
        mem_write = 1'b1;
        if (MemReady) state_next = S_FETCH;
      end
      S_EXECUTER: begin
        src_a      = SRCA_RS1;
        alu_class  = CLS_RTYPE;
        state_next = S_ALUWB;
      end
      S_EXECUTEI: begin
        src_a      = SRCA_RS1;
        src_b      = SRCB_IMM;
        alu_class  = CLS_ITYPE;
        state_next = S_ALUWB;
      end
      S_ALUWB: begin
        reg_write  = 1'b1;
        state_next = S_FETCH;
      end
      S_LUI: begin
        src_b      = SRCB_IMM;
        alu_class  = CLS_PASSB;
        state_next = S_ALUWB;
      end
      S_BRANCH: begin
        src_a      = SRCA_RS1;
        alu_class  = CLS_SUB;
        pc_write   = taken_c;
        state_next = S_FETCH;
      end
      S_JAL: begin
        src_a      = SRCA_OLDPC;
        src_b      = SRCB_FOUR;
        pc_write   = 1'b1;
        state_next = S_ALUWB;
      end
      S_JALR: begin
        src_a      = SRCA_RS1;
        src_b      = SRCB_IMM;
        result_src = RES_ALURESULT;
        pc_write   = 1'b1;
        state_next = S_JALR_LINK;
      end
      S_JALR_LINK: begin
        src_a      = SRCA_OLDPC;
        src_b      = SRCB_FOUR;
        state_next = S_ALUWB;
      end
      S_TRAP:  state_next = S_TRAP;
      default: state_next = S_TRAP;
    endcase
  end

  assign retire_c = (state_next == S_FETCH) &&
                    (state inside {S_MEMWB, S_MEMWRITE, S_ALUWB, S_BRANCH});

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_FETCH;
      illegal_q <= 1'b0;
      retired_q <= '0;
    end else begin
      state <= state_next;
      if (state_next == S_TRAP) illegal_q <= 1'b1;
      if (retire_c) retired_q <= retired_q + RETIRE_W'(1);
    end
  end

  // Strobes are gated by reset so an aborted instruction has no side effects.
  assign PCWrite      = pc_write  & rst_n;
  assign IRWrite      = ir_write  & rst_n;
  assign MemWrite     = mem_write & rst_n;
  assign RegWrite     = reg_write & rst_n;
  assign AdrSrc       = adr_src;
  assign ResultSrc    = result_src;
  assign ALUSrcA      = src_a;
  assign ALUSrcB      = src_b;
  assign ALUControl   = ALU_CTRL_W'(alu_ctrl_c);
  assign ImmSrc       = IMM_SRC_W'(imm_src);
  assign IllegalInstr = illegal_q;
  assign InstRetired  = retired_q;
  assign State        = state;

endmodule
